seq_decimalizer: RTL and testbench

//   Multi-channel, sequential binary-to-BCD converter (shift-add-3, "double dabble").

---
 rtl/seq_decimalizer_if.sv | 32 +++
 rtl/seq_decimalizer.sv | 205 ++++++++++++++++++++
 tb/tb_seq_decimalizer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_decimalizer_if.sv
// seq_decimalizer_if: start/done handshake and data bus between a requester
// (game-state side) and the sequential binary-to-BCD converter.
interface seq_decimalizer_if #(
  parameter int W_IN     = 6,
  parameter int DIGITS   = 2,
  parameter int CHANNELS = 3
);
  logic                           start_i;
  logic [CHANNELS*W_IN-1:0]       value_i;
  logic                           ready_o;
  logic                           done_o;
  logic [CHANNELS*DIGITS*4-1:0]   bcd_o;
  logic [CHANNELS-1:0]            ovf_o;

  modport master (
    output start_i,
    output value_i,
    input  ready_o,
    input  done_o,
    input  bcd_o,
    input  ovf_o
  );

  modport slave (
    input  start_i,
    input  value_i,
    output ready_o,
    output done_o,
    output bcd_o,
    output ovf_o
  );
endinterface

// File: rtl/seq_decimalizer.sv
// seq_decimalizer: multi-channel sequential binary-to-BCD converter using
// shift-add-3 (double dabble). All channels convert in lock-step, one input
// bit per clock. Results saturate to all-9s when a channel does not fit in
// DIGITS decimal digits.
// Build option: define SEQ_DECIMALIZER_BLANK_EN to replace leading zero digits
// with 4'hF ("blank" for the font ROM); the units digit is never blanked.

// Checker: every accumulator digit must remain a valid BCD value (0..9).
module seq_decimalizer_chk #(
  parameter int NDIG = 6
) (
  input logic              clk,
  input logic              rst_n,
  input logic [NDIG*4-1:0] acc_i
);
  // Check each accumulator digit after every clock edge while out of reset.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NDIG; i++) begin
        assert (acc_i[i*4 +: 4] <= 4'd9);
      end
    end
  end
endmodule

module seq_decimalizer #(
  parameter int W_IN     = 6,
  parameter int DIGITS   = 2,
  parameter int CHANNELS = 3
) (
  input logic               clk,
  input logic               rst_n,
  seq_decimalizer_if.slave  bus
);
  // Internal digit count that always covers 2^W_IN-1.
  localparam int DI   = (W_IN + 2) / 3;
  localparam int MAXD = (DI > DIGITS) ? DI : DIGITS;
  localparam int CW   = $clog2(W_IN + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                               state_q, state_d;
  logic [CW-1:0]                        cnt_q, cnt_d;
  logic [CHANNELS-1:0][W_IN-1:0]        shreg_q, shreg_d, shreg_step_s;
  logic [CHANNELS-1:0][DI*4-1:0]        acc_q, acc_d, acc_step_s;
  logic [CHANNELS*DIGITS*4-1:0]         bcd_q, bcd_d, fmt_bcd_s;
  logic [CHANNELS-1:0]                  ovf_q, ovf_d, fmt_ovf_s;
  logic [CHANNELS-1:0][DIGITS*4:0]      fmt_res_s;
  logic                                 ready_q, ready_d;
  logic                                 done_q, done_d;

  // Add-3 correction for one BCD digit ahead of a left shift.
  function automatic logic [3:0] dig_adj(input logic [3:0] dig);
    if (dig >= 4'd5) begin
      return dig + 4'd3;
    end else begin
      return dig;
    end
  endfunction

  // One double-dabble step of a channel accumulator: correct then shift in a bit.
  function automatic logic [DI*4-1:0] acc_shift(input logic [DI*4-1:0] acc,
                                                input logic            in_bit);
    logic [DI*4-1:0] a;
    a = acc;
    for (int d = 0; d < DI; d++) begin
      a[d*4 +: 4] = dig_adj(acc[d*4 +: 4]);
    end
    return {a[DI*4-2:0], in_bit};
  endfunction

  // Map a finished accumulator to {ovf, DIGITS digits}: saturate, extend, blank.
  function automatic logic [DIGITS*4:0] fmt_channel(input logic [DI*4-1:0] acc);
    logic [MAXD*4-1:0]   w;
    logic                ovf;
    logic [DIGITS*4-1:0] o;
`ifdef SEQ_DECIMALIZER_BLANK_EN
    logic                lead;
`endif
    w            = '0;
    w[DI*4-1:0]  = acc;
    ovf          = 1'b0;
    for (int d = DIGITS; d < MAXD; d++) begin
      ovf = ovf | (w[d*4 +: 4] != 4'd0);
    end
    for (int d = 0; d < DIGITS; d++) begin
      o[d*4 +: 4] = ovf ? 4'h9 : w[d*4 +: 4];
    end
`ifdef SEQ_DECIMALIZER_BLANK_EN
    // Saturated results carry no leading zeros, so blanking never touches them.
    lead = ~ovf;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (lead && (o[d*4 +: 4] == 4'd0)) begin
        o[d*4 +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
`endif
    return {ovf, o};
  endfunction

  // Datapath step for all channels: the accumulator/shift values after one bit.
  always_comb begin
    acc_step_s   = acc_q;
    shreg_step_s = shreg_q;
    for (int c = 0; c < CHANNELS; c++) begin
      acc_step_s[c]   = acc_shift(acc_q[c], shreg_q[c][W_IN-1]);
      shreg_step_s[c] = shreg_q[c] << 1;
    end
  end

  // Output formatting from the post-shift accumulators (used on the last bit).
  always_comb begin
    fmt_res_s = '0;
    fmt_bcd_s = '0;
    fmt_ovf_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      fmt_res_s[c]                          = fmt_channel(acc_step_s[c]);
      fmt_bcd_s[c*DIGITS*4 +: DIGITS*4]     = fmt_res_s[c][DIGITS*4-1:0];
      fmt_ovf_s[c]                          = fmt_res_s[c][DIGITS*4];
    end
  end

  // Next-state logic: IDLE accepts, CONV shifts W_IN bits, DONE pulses for one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          shreg_d = bus.value_i;
          acc_d   = '0;
          cnt_d   = CW'(W_IN);
          state_d = ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        acc_d   = acc_step_s;
        shreg_d = shreg_step_s;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Last bit: capture the formatted result as we enter DONE.
          bcd_d   = fmt_bcd_s;
          ovf_d   = fmt_ovf_s;
          state_d = ST_DONE;
        end else begin
          state_d = ST_CONV;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.done_o  = done_q;
  assign bus.bcd_o   = bcd_q;
  assign bus.ovf_o   = ovf_q;

  seq_decimalizer_chk #(.NDIG(CHANNELS*DI)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .acc_i (acc_q)
  );
endmodule

// File: tb/tb_seq_decimalizer.sv
// tb_seq_decimalizer: scoreboard bench for seq_decimalizer with a 6-bit
// (default) instance and a 7-bit instance for saturation cases.
module tb_seq_decimalizer;
  localparam int W6 = 6;
  localparam int W7 = 7;
  localparam int DG = 2;
  localparam int CH = 3;

  typedef struct packed {
    logic [CH*DG*4-1:0] bcd;
    logic [CH-1:0]      ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t exp7_q[$];
  exp_t e;

  always #5 clk = ~clk;

  seq_decimalizer_if #(.W_IN(W6), .DIGITS(DG), .CHANNELS(CH)) bus6 ();
  seq_decimalizer_if #(.W_IN(W7), .DIGITS(DG), .CHANNELS(CH)) bus7 ();

  seq_decimalizer #(.W_IN(W6), .DIGITS(DG), .CHANNELS(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  seq_decimalizer #(.W_IN(W7), .DIGITS(DG), .CHANNELS(CH)) dut7 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus7)
  );

  // Reference for one channel: {ovf, tens, units}.
  function automatic logic [8:0] chan_model(int v);
    logic [3:0] d1, d0;
    logic       ov;
    if (v >= 100) begin
      ov = 1'b1; d1 = 4'd9; d0 = 4'd9;
    end else begin
      ov = 1'b0; d1 = 4'(v / 10); d0 = 4'(v % 10);
    end
`ifdef SEQ_DECIMALIZER_BLANK_EN
    if (!ov && d1 == 4'd0) d1 = 4'hF;
`endif
    return {ov, d1, d0};
  endfunction

  function automatic exp_t model(int v2, int v1, int v0);
    exp_t r;
    logic [8:0] c0, c1, c2;
    c0 = chan_model(v0);
    c1 = chan_model(v1);
    c2 = chan_model(v2);
    r.bcd = {c2[7:0], c1[7:0], c0[7:0]};
    r.ovf = {c2[8], c1[8], c0[8]};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus6.start_i = 1'b0; bus6.value_i = '0;
    bus7.start_i = 1'b0; bus7.value_i = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++; if (bus6.ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus6.ready_o); end
    checks++; if (bus6.done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus6.done_o); end
    checks++; if (bus6.bcd_o !== 24'h0) begin failures++; $display("FAIL reset_bcd got=%h want=0", bus6.bcd_o); end
    checks++; if (bus6.ovf_o !== 3'b000) begin failures++; $display("FAIL reset_ovf got=%b want=000", bus6.ovf_o); end
    checks++; if (bus7.ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready7 got=%b want=1", bus7.ready_o); end
  endtask

  task automatic test_basic();
    int tbl [3][3];
    tbl = '{'{42, 0, 63}, '{0, 0, 0}, '{63, 63, 1}};
    for (int t = 0; t < 3; t++) begin
      int n;
      bus6.value_i = {6'(tbl[t][0]), 6'(tbl[t][1]), 6'(tbl[t][2])};
      bus6.start_i = 1'b1;
      exp_q.push_back(model(tbl[t][0], tbl[t][1], tbl[t][2]));
      step();
      bus6.start_i = 1'b0;
      bus6.value_i = ~bus6.value_i;  // changes after acceptance must not matter
      checks++; if (bus6.ready_o !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b want=0", bus6.ready_o); end
      n = 0;
      while (bus6.done_o !== 1'b1 && n < 30) begin step(); n++; end
      checks++; if (n !== W6) begin failures++; $display("FAIL basic_latency got=%0d want=%0d", n, W6); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      checks++; if (bus6.bcd_o !== e.bcd) begin failures++; $display("FAIL basic_bcd got=%h want=%h", bus6.bcd_o, e.bcd); end
      checks++; if (bus6.ovf_o !== e.ovf) begin failures++; $display("FAIL basic_ovf got=%b want=%b", bus6.ovf_o, e.ovf); end
      step();
      checks++; if (bus6.done_o !== 1'b0) begin failures++; $display("FAIL basic_pulse got=%b want=0", bus6.done_o); end
      checks++; if (bus6.ready_o !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b want=1", bus6.ready_o); end
    end
  endtask

  task automatic test_saturate();
    int tbl [2][3];
    tbl = '{'{100, 99, 127}, '{0, 5, 127}};
    for (int t = 0; t < 2; t++) begin
      int n;
      bus7.value_i = {7'(tbl[t][0]), 7'(tbl[t][1]), 7'(tbl[t][2])};
      bus7.start_i = 1'b1;
      exp7_q.push_back(model(tbl[t][0], tbl[t][1], tbl[t][2]));
      step();
      bus7.start_i = 1'b0;
      n = 0;
      while (bus7.done_o !== 1'b1 && n < 30) begin step(); n++; end
      checks++; if (n !== W7) begin failures++; $display("FAIL sat_latency got=%0d want=%0d", n, W7); end
      e = (exp7_q.size() > 0) ? exp7_q.pop_front() : '0;
      checks++; if (bus7.bcd_o !== e.bcd) begin failures++; $display("FAIL sat_bcd got=%h want=%h", bus7.bcd_o, e.bcd); end
      checks++; if (bus7.ovf_o !== e.ovf) begin failures++; $display("FAIL sat_ovf got=%b want=%b", bus7.ovf_o, e.ovf); end
      step();
    end
  endtask

  task automatic test_ignore_busy();
    int n;
    int extra;
    bus6.value_i = {6'd11, 6'd22, 6'd33};
    exp_q.push_back(model(11, 22, 33));
    bus6.start_i = 1'b1;
    step();
    bus6.start_i = 1'b0;
    step(); step();
    bus6.value_i = {6'd50, 6'd60, 6'd7};
    bus6.start_i = 1'b1;
    step();
    bus6.start_i = 1'b0;
    bus6.value_i = '0;
    n = 0;
    while (bus6.done_o !== 1'b1 && n < 30) begin step(); n++; end
    checks++; if (n !== 3) begin failures++; $display("FAIL ignore_latency got=%0d want=3", n); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++; if (bus6.bcd_o !== e.bcd) begin failures++; $display("FAIL ignore_bcd got=%h want=%h", bus6.bcd_o, e.bcd); end
    checks++; if (bus6.ovf_o !== e.ovf) begin failures++; $display("FAIL ignore_ovf got=%b want=%b", bus6.ovf_o, e.ovf); end
    extra = 0;
    repeat (20) begin step(); if (bus6.done_o === 1'b1) extra++; end
    checks++; if (extra !== 0) begin failures++; $display("FAIL ignore_extra_done got=%0d want=0", extra); end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy, exp_done;
    for (int k = 0; k < 32; k++) begin
      bus6.value_i = 18'($urandom);
      bus6.start_i = 1'b1;
      exp_rdy = (k % 8 == 0);
      checks++; if (bus6.ready_o !== exp_rdy) begin failures++; $display("FAIL b2b_ready k=%0d got=%b want=%b", k, bus6.ready_o, exp_rdy); end
      if (exp_rdy) exp_q.push_back(model(int'(bus6.value_i[17:12]), int'(bus6.value_i[11:6]), int'(bus6.value_i[5:0])));
      step();
      exp_done = (k % 8 == 6);
      checks++; if (bus6.done_o !== exp_done) begin failures++; $display("FAIL b2b_done k=%0d got=%b want=%b", k, bus6.done_o, exp_done); end
      if (exp_done) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++; if (bus6.bcd_o !== e.bcd) begin failures++; $display("FAIL b2b_bcd got=%h want=%h", bus6.bcd_o, e.bcd); end
        checks++; if (bus6.ovf_o !== e.ovf) begin failures++; $display("FAIL b2b_ovf got=%b want=%b", bus6.ovf_o, e.ovf); end
      end
    end
    bus6.start_i = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    int extra;
    bus6.value_i = {6'd59, 6'd48, 6'd37};
    exp_q.push_back(model(59, 48, 37));
    bus6.start_i = 1'b1;
    step();
    bus6.start_i = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++; if (bus6.ready_o !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b want=1", bus6.ready_o); end
    checks++; if (bus6.done_o !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b want=0", bus6.done_o); end
    checks++; if (bus6.bcd_o !== 24'h0) begin failures++; $display("FAIL midrst_bcd got=%h want=0", bus6.bcd_o); end
    checks++; if (bus6.ovf_o !== 3'b000) begin failures++; $display("FAIL midrst_ovf got=%b want=000", bus6.ovf_o); end
    step(); step();
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (15) begin step(); if (bus6.done_o === 1'b1) extra++; end
    checks++; if (extra !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d want=0", extra); end
    bus6.value_i = {6'd1, 6'd2, 6'd3};
    exp_q.push_back(model(1, 2, 3));
    bus6.start_i = 1'b1;
    step();
    bus6.start_i = 1'b0;
    n = 0;
    while (bus6.done_o !== 1'b1 && n < 30) begin step(); n++; end
    checks++; if (n !== W6) begin failures++; $display("FAIL midrst_latency got=%0d want=%0d", n, W6); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++; if (bus6.bcd_o !== e.bcd) begin failures++; $display("FAIL midrst_bcd_after got=%h want=%h", bus6.bcd_o, e.bcd); end
    step();
  endtask

  task automatic test_blank();
    int n;
    bus6.value_i = {6'd10, 6'd0, 6'd5};
    exp_q.push_back(model(10, 0, 5));
    bus6.start_i = 1'b1;
    step();
    bus6.start_i = 1'b0;
    n = 0;
    while (bus6.done_o !== 1'b1 && n < 30) begin step(); n++; end
    checks++; if (n !== W6) begin failures++; $display("FAIL blank_latency got=%0d want=%0d", n, W6); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++; if (bus6.bcd_o !== e.bcd) begin failures++; $display("FAIL blank_bcd got=%h want=%h", bus6.bcd_o, e.bcd); end
    checks++; if (bus6.ovf_o !== e.ovf) begin failures++; $display("FAIL blank_ovf got=%b want=%b", bus6.ovf_o, e.ovf); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_blank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end
endmodule
